regfile_sb: RTL and testbench

- Parametrised register file with a per-register pending (scoreboard) bit and a sequential clear engine.
- Provides two combinational read ports with write bypass and one synchronous write port.
- Issue logic marks a destination pending; writeback clears the mark. Read ports report operand readiness to hazard/stall logic.
- After reset, or on request, an internal FSM sweeps every entry to CLR_VAL, one per cycle.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_sb_rd_port.sv | 48 ++++
 rtl/regfile_sb.sv | 137 +++++++++++++
 tb/tb_regfile_sb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the scoreboarded register file.
// Optional feature macro: REGFILE_R0_ZERO_EN (address 0 hardwired to zero, always ready
// outside a clear sweep, writes/issues to it ignored).
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR,
        RF_IDLE
    } rf_state_t;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 5;

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

endpackage

// File: rtl/regfile_sb_rd_port.sv
// Combinational read port: write-first bypass plus operand-ready logic.
// Honours REGFILE_R0_ZERO_EN through regfile_pkg::R0_ZERO.
// Ports:
//   addr     read address
//   pending  scoreboard vector, one bit per entry
//   word     array contents at addr
//   wr_en    raw write strobe
//   wr_addr  write address
//   wr_data  write data
//   busy     clear sweep in progress
//   data     read data
//   rdy      operand valid (not pending, not sweeping)
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic [2**ADDR_W-1:0]   pending,
    input  logic [DATA_W-1:0]      word,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   busy,
    output logic [DATA_W-1:0]      data,
    output logic                   rdy
);

    always_comb begin
        data = word;
        rdy  = ~pending[addr];
        // A write in flight this cycle is forwarded and its result is by definition ready.
        if (!busy && wr_en && (wr_addr == addr)) begin
            data = wr_data;
            rdy  = 1'b1;
        end
        if (R0_ZERO && (addr == '0)) begin
            data = '0;
            rdy  = 1'b1;
        end
        // Nothing is ready while the sweep is rewriting the array.
        if (busy) begin
            rdy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-entry pending (scoreboard) bits and a sequential clear sweep.
// Optional feature macro: REGFILE_R0_ZERO_EN (see regfile_pkg).
// Ports:
//   clk, rst             clock, asynchronous active-high reset (starts a sweep)
//   src1/src2            read addresses; reg1/reg2 data, reg1_rdy/reg2_rdy readiness
//   dest, Write_val      write address/data; Write_EN writes and clears pending[dest]
//   iss_en, iss_dest     issue strobe; sets pending[iss_dest]
//   clr_req              start a clear sweep from idle
//   busy                 clear sweep in progress
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic              reg1_rdy,
    output logic              reg2_rdy,
    input  logic [ADDR_W-1:0] dest,
    input  logic [DATA_W-1:0] Write_val,
    input  logic              Write_EN,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_dest,
    input  logic              clr_req,
    output logic              busy
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_t           state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DEPTH-1:0]    pending_q, pending_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                wr_ok;
    logic                iss_ok;

    assign busy   = (state_q == RF_CLEAR);
    assign wr_ok  = Write_EN && !(R0_ZERO && (dest == '0));
    assign iss_ok = iss_en && !(R0_ZERO && (iss_dest == '0));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        mem_we    = 1'b0;
        mem_waddr = idx_q;
        mem_wdata = CLR_VAL;
        unique case (state_q)
            RF_CLEAR: begin
                mem_we = 1'b1;
                idx_d  = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = RF_IDLE;
                end
            end
            RF_IDLE: begin
                if (clr_req) begin
                    state_d   = RF_CLEAR;
                    idx_d     = '0;
                    pending_d = '0;
                end else begin
                    if (wr_ok) begin
                        mem_we          = 1'b1;
                        mem_waddr       = dest;
                        mem_wdata       = Write_val;
                        pending_d[dest] = 1'b0;
                    end
                    // Applied after the write so a same-address issue keeps the entry pending.
                    if (iss_ok) begin
                        pending_d[iss_dest] = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            idx_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end

    // Array is deliberately not reset; the sweep initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd1 (
        .addr    (src1),
        .pending (pending_q),
        .word    (mem[src1]),
        .wr_en   (Write_EN),
        .wr_addr (dest),
        .wr_data (Write_val),
        .busy    (busy),
        .data    (reg1),
        .rdy     (reg1_rdy)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd2 (
        .addr    (src2),
        .pending (pending_q),
        .word    (mem[src2]),
        .wr_en   (Write_EN),
        .wr_addr (dest),
        .wr_data (Write_val),
        .busy    (busy),
        .data    (reg2),
        .rdy     (reg2_rdy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios followed by random traffic,
// checked against a behavioural model (array + pending flags + sweep countdown).
module tb_regfile_sb;

    localparam int DEPTH = 32;
`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [4:0]  src1, src2, dest, iss_dest;
    logic [31:0] reg1, reg2, Write_val;
    logic        reg1_rdy, reg2_rdy, Write_EN, iss_en, clr_req, busy;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [31:0] m_mem [DEPTH];
    bit          m_pend [DEPTH];
    int          m_clear_left;

    regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .src1      (src1),
        .src2      (src2),
        .reg1      (reg1),
        .reg2      (reg2),
        .reg1_rdy  (reg1_rdy),
        .reg2_rdy  (reg2_rdy),
        .dest      (dest),
        .Write_val (Write_val),
        .Write_EN  (Write_EN),
        .iss_en    (iss_en),
        .iss_dest  (iss_dest),
        .clr_req   (clr_req),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // A sweep (re)starts from reset release: all pending flags drop, DEPTH busy cycles follow.
    function automatic void model_reset();
        m_clear_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
    endfunction

    function automatic void model_read(input logic [4:0] a, output logic [31:0] d,
                                       output bit r);
        if (m_clear_left > 0) begin
            d = 32'h0;
            r = 1'b0;
        end else if (R0Z && a == 0) begin
            d = 32'h0;
            r = 1'b1;
        end else if (Write_EN && dest == a) begin
            d = Write_val;
            r = 1'b1;
        end else begin
            d = m_mem[a];
            r = !m_pend[a];
        end
    endfunction

    function automatic void model_edge();
        if (m_clear_left > 0) begin
            m_clear_left--;
            if (m_clear_left == 0)
                for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        end else if (clr_req) begin
            m_clear_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
        end else begin
            if (Write_EN && !(R0Z && dest == 0)) begin
                m_mem[dest]  = Write_val;
                m_pend[dest] = 1'b0;
            end
            if (iss_en && !(R0Z && iss_dest == 0)) m_pend[iss_dest] = 1'b1;
        end
    endfunction

    // Mid-cycle: compare all outputs with the model.
    task automatic settle(input string tag);
        logic [31:0] d1, d2;
        bit          r1, r2;
        #4;
        model_read(src1, d1, r1);
        model_read(src2, d2, r2);
        check({tag, ".busy"}, 32'(busy), 32'(m_clear_left > 0));
        check({tag, ".rdy1"}, 32'(reg1_rdy), 32'(r1));
        check({tag, ".rdy2"}, 32'(reg2_rdy), 32'(r2));
        if (m_clear_left == 0) begin
            check({tag, ".reg1"}, reg1, d1);
            check({tag, ".reg2"}, reg2, d2);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        Write_EN = 1'b0;
        iss_en   = 1'b0;
        clr_req  = 1'b0;
    endtask

    // Count busy cycles; bounded so a stuck sweep still reaches the summary.
    task automatic count_sweep(input string tag);
        int n = 0;
        settle(tag);
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
            settle(tag);
        end
        check({tag, ".len"}, 32'(n), 32'd32);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        rst = 1'b1;
        src1 = '0; src2 = '0; dest = '0; iss_dest = '0; Write_val = '0;
        idle_inputs();
        model_reset();

        // 1. Reset state and sweep length
        #12;
        check("rst.busy", 32'(busy), 32'd1);
        check("rst.rdy1", 32'(reg1_rdy), 32'd0);
        check("rst.rdy2", 32'(reg2_rdy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        count_sweep("sweep0");
        src1 = 5'd17; src2 = 5'd31;
        settle("post0");
        check("post0.reg1", reg1, 32'h0);
        check("post0.rdy2", 32'(reg2_rdy), 32'd1);
        tick();

        // 2. Write bypass
        dest = 5'd5; Write_val = 32'hDEADBEEF; Write_EN = 1'b1; src1 = 5'd5;
        settle("byp");
        check("byp.reg1", reg1, 32'hDEADBEEF);
        check("byp.rdy1", 32'(reg1_rdy), 32'd1);
        tick();
        Write_EN = 1'b0;
        settle("byp2");
        check("byp2.reg1", reg1, 32'hDEADBEEF);
        tick();

        // 3. Scoreboard set and clear
        iss_en = 1'b1; iss_dest = 5'd7; src2 = 5'd7;
        settle("iss");
        tick();
        iss_en = 1'b0;
        settle("iss2");
        check("iss2.rdy2", 32'(reg2_rdy), 32'd0);
        tick();
        Write_EN = 1'b1; dest = 5'd7; Write_val = 32'h12;
        settle("wb");
        check("wb.reg2", reg2, 32'h12);
        check("wb.rdy2", 32'(reg2_rdy), 32'd1);
        tick();
        Write_EN = 1'b0;
        settle("wb2");
        check("wb2.rdy2", 32'(reg2_rdy), 32'd1);
        tick();

        // 4. Same-address write and issue: set wins
        Write_EN = 1'b1; iss_en = 1'b1; dest = 5'd3; iss_dest = 5'd3; Write_val = 32'h55;
        src1 = 5'd3;
        settle("col");
        tick();
        idle_inputs();
        settle("col2");
        check("col2.reg1", reg1, 32'h55);
        check("col2.rdy1", 32'(reg1_rdy), 32'd0);
        tick();

        // 5. Clear request; writes during sweep ignored
        for (int i = 1; i <= 4; i++) begin
            Write_EN = 1'b1; dest = 5'(i); Write_val = 32'h100 + 32'(i);
            settle("fill");
            tick();
        end
        Write_EN = 1'b0; iss_en = 1'b1; iss_dest = 5'd9;
        settle("iss9");
        tick();
        iss_en = 1'b0; clr_req = 1'b1;
        settle("clr");
        tick();
        clr_req = 1'b0;
        Write_EN = 1'b1; dest = 5'd1; Write_val = 32'hFFFF; iss_en = 1'b1; iss_dest = 5'd2;
        count_sweep("sweep1");
        idle_inputs();
        tick();
        for (int i = 1; i <= 4; i++) begin
            src1 = 5'(i); src2 = 5'd9;
            settle("aft");
            check("aft.reg1", reg1, 32'h0);
            check("aft.rdy1", 32'(reg1_rdy), 32'd1);
            check("aft.rdy9", 32'(reg2_rdy), 32'd1);
            tick();
        end

        // 6. Reset in the middle of a sweep
        clr_req = 1'b1;
        settle("clr2");
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle("mid");
            tick();
        end
        rst = 1'b1;
        #1;
        check("midrst.busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        count_sweep("sweep2");
        tick();
        Write_EN = 1'b1; dest = 5'd0; Write_val = 32'hFFFF;
        settle("r0w");
        tick();
        Write_EN = 1'b0; src1 = 5'd0;
        settle("r0r");
        check("r0r.reg1", reg1, R0Z ? 32'h0 : 32'hFFFF);
        check("r0r.rdy1", 32'(reg1_rdy), 32'd1);
        tick();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            src1      = 5'($urandom_range(0, 31));
            src2      = ($urandom_range(0, 3) == 0) ? src1 : 5'($urandom_range(0, 31));
            dest      = 5'($urandom_range(0, 31));
            iss_dest  = ($urandom_range(0, 3) == 0) ? dest : 5'($urandom_range(0, 31));
            Write_val = $urandom;
            Write_EN  = ($urandom_range(0, 1) == 1);
            iss_en    = ($urandom_range(0, 2) == 0);
            clr_req   = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) == 0) src1 = dest;
            settle("rnd");
            tick();
        end

        idle_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
